// File: rtl/proc_fetch_sequencer.sv
// Instruction-address sequencer for the multicycle processor: issues one run
// pulse per address from START_ADDR to the latched stop address, waiting on done.
module proc_fetch_sequencer #(
  parameter int ADDR_W     = 5,
  parameter int START_ADDR = 0,
  parameter int TIMEOUT    = 32,
  parameter int CNT_W      = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] stop_addr,
  input  logic              single_step,
  input  logic              step,
  input  logic              done,
  output logic [ADDR_W-1:0] Din,
  output logic              run,
  output logic              busy,
  output logic              finished,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_PAUSE, S_HALT, S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDR);
  localparam logic [7:0]        TIMER_MAX = 8'(TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] stop_reg;
  logic [7:0]        timer_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_HALT, S_ERROR: if (start) state_next = S_ISSUE;
      S_ISSUE:                 state_next = S_WAIT;
      S_WAIT: begin
        // done takes priority over an expiring watchdog in the same cycle
        if (done)                         state_next = (Din == stop_reg) ? S_HALT : S_NEXT;
        else if (timer_reg == TIMER_MAX)  state_next = S_ERROR;
      end
      S_NEXT:  if (!done) state_next = single_step ? S_PAUSE : S_ISSUE;
      S_PAUSE: if (step)  state_next = S_ISSUE;
      default:            state_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      Din         <= START_A;
      stop_reg    <= '0;
      timer_reg   <= '0;
      run         <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      timeout_err <= 1'b0;
      instr_count <= '0;
    end else begin
      state_reg   <= state_next;
      run         <= (state_next == S_ISSUE);
      busy        <= (state_next == S_ISSUE) || (state_next == S_WAIT) ||
                     (state_next == S_NEXT)  || (state_next == S_PAUSE);
      finished    <= (state_next == S_HALT);
      timeout_err <= (state_next == S_ERROR);
      case (state_reg)
        S_IDLE, S_HALT, S_ERROR: begin
          if (start) begin
            Din         <= START_A;
            stop_reg    <= stop_addr;
            instr_count <= '0;
          end
        end
        S_ISSUE: timer_reg <= '0;
        S_WAIT: begin
          timer_reg <= timer_reg + 8'd1;
          if (done && (instr_count != '1)) instr_count <= instr_count + 1'b1;
        end
        S_NEXT: if (!done) Din <= Din + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_fetch_sequencer.sv
// Randomized self-checking bench for proc_fetch_sequencer with a simple
// processor model and an address-list reference model.
module tb_proc_fetch_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       single_step = 1'b0;
  logic       step = 1'b0;
  logic [4:0] stop_addr = 5'd0;
  logic       done0, done1;
  logic [4:0] din0, din1;
  logic       run0, run1, busy0, busy1, fin0, fin1, terr0, terr1;
  logic [7:0] cnt0, cnt1;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  proc_fetch_sequencer #(.ADDR_W(5), .START_ADDR(0), .TIMEOUT(32), .CNT_W(8)) dut0 (
    .clock(clock), .reset(reset), .start(start), .stop_addr(stop_addr),
    .single_step(single_step), .step(step), .done(done0), .Din(din0), .run(run0),
    .busy(busy0), .finished(fin0), .timeout_err(terr0), .instr_count(cnt0));

  proc_fetch_sequencer #(.ADDR_W(5), .START_ADDR(30), .TIMEOUT(32), .CNT_W(8)) dut1 (
    .clock(clock), .reset(reset), .start(start), .stop_addr(stop_addr),
    .single_step(single_step), .step(step), .done(done1), .Din(din1), .run(run1),
    .busy(busy1), .finished(fin1), .timeout_err(terr1), .instr_count(cnt1));

  // Processor model: done is high from proc_lat to proc_lat+proc_hold-1 cycles after run.
  int proc_lat = 4;
  int proc_hold = 1;
  bit proc_en = 1'b1;
  bit ovr = 1'b0;
  bit ovr_val = 1'b0;
  int c0 = 0;
  int c1 = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) c0 <= 0;
    else if (run0) c0 <= 1;
    else if (c0 != 0 && c0 < 1000) c0 <= c0 + 1;
  end
  always @(posedge clock or negedge reset) begin
    if (!reset) c1 <= 0;
    else if (run1) c1 <= 1;
    else if (c1 != 0 && c1 < 1000) c1 <= c1 + 1;
  end
  assign done0 = ovr ? ovr_val : (proc_en && c0 >= proc_lat && c0 < proc_lat + proc_hold);
  assign done1 = ovr ? ovr_val : (proc_en && c1 >= proc_lat && c1 < proc_lat + proc_hold);

  // Run-pulse monitors
  int cyc = 0;
  logic [4:0] q0[$];
  int t0[$];
  logic [4:0] q1[$];
  int t1[$];
  logic dq1[$];
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (run0) begin
      q0.push_back(din0);
      t0.push_back(cyc);
      $display("run dut0 addr=%0d cycle=%0d", din0, cyc);
    end
    if (run1) begin
      q1.push_back(din1);
      t1.push_back(cyc);
      dq1.push_back(done1);
    end
  end

  // Reference: the list of addresses a run from s to e must issue.
  int exp_q[$];
  task automatic model_prog(input int s, input int e);
    int a;
    exp_q.delete();
    a = s;
    forever begin
      exp_q.push_back(a);
      if (a == e) break;
      a = (a + 1) % 32;
    end
  endtask

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    ovr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      ovr_val = ~ovr_val;
      total++;
      if ({run0, busy0, fin0, terr0, din0, cnt0} !== 17'd0) begin
        bad++;
        $display("FAIL reset_outputs: run=%b busy=%b fin=%b terr=%b din=%0d cnt=%0d, required all 0",
                 run0, busy0, fin0, terr0, din0, cnt0);
      end
    end
    ovr = 1'b0;
    start = 1'b0;
    @(negedge clock) reset = 1'b1;
    repeat (5) @(negedge clock);
    total++;
    if (busy0 !== 1'b0 || q0.size() != 0 || din0 !== 5'd0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b runs=%0d din=%0d, required busy=0 runs=0 din=0",
               busy0, q0.size(), din0);
    end
  endtask

  task automatic run_program(input int stop, input int lat, input int hold, input string name);
    int b;
    int n;
    b = q0.size();
    proc_lat = lat;
    proc_hold = hold;
    stop_addr = 5'(stop);
    pulse_start();
    stop_addr = 5'($urandom_range(0, 31));
    model_prog(0, stop);
    for (int i = 0; i < 800 && !fin0; i++) @(negedge clock);
    total++;
    if (fin0 !== 1'b1) begin
      bad++;
      $display("FAIL %s_finish: finished=%b, required 1", name, fin0);
    end
    n = q0.size() - b;
    total++;
    if (n != exp_q.size()) begin
      bad++;
      $display("FAIL %s_nruns: got %0d, required %0d", name, n, exp_q.size());
    end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      total++;
      if (int'(q0[b+i]) != exp_q[i]) begin
        bad++;
        $display("FAIL %s_addr[%0d]: got %0d, required %0d", name, i, q0[b+i], exp_q[i]);
      end
      if (i > 0) begin
        total++;
        if (t0[b+i] - t0[b+i-1] != lat + hold + 1) begin
          bad++;
          $display("FAIL %s_gap[%0d]: got %0d, required %0d", name, i,
                   t0[b+i] - t0[b+i-1], lat + hold + 1);
        end
      end
    end
    total++;
    if (int'(cnt0) != exp_q.size() || int'(din0) != stop) begin
      bad++;
      $display("FAIL %s_final: cnt=%0d din=%0d, required cnt=%0d din=%0d",
               name, cnt0, din0, exp_q.size(), stop);
    end
    repeat (20) @(negedge clock);
    total++;
    if (q0.size() - b != n || fin0 !== 1'b1) begin
      bad++;
      $display("FAIL %s_quiet: runs=%0d fin=%b, required runs=%0d fin=1",
               name, q0.size() - b, fin0, n);
    end
  endtask

  task automatic test_free_run();
    run_program(3, 4, 1, "free");
  endtask

  task automatic test_random_runs();
    for (int k = 0; k < 4; k++)
      run_program($urandom_range(0, 31), $urandom_range(1, 6), $urandom_range(1, 3), "rand");
  endtask

  task automatic test_single_step();
    int b;
    b = q0.size();
    proc_lat = 3;
    proc_hold = 1;
    single_step = 1'b1;
    stop_addr = 5'd2;
    model_prog(0, 2);
    pulse_start();
    repeat (20) @(negedge clock);
    total++;
    if (q0.size() - b != 1 || din0 !== 5'd1 || busy0 !== 1'b1 || cnt0 !== 8'd1) begin
      bad++;
      $display("FAIL step_pause: runs=%0d din=%0d busy=%b cnt=%0d, required 1 1 1 1",
               q0.size() - b, din0, busy0, cnt0);
    end
    for (int k = 1; k <= 2; k++) begin
      @(negedge clock) step = 1'b1;
      @(negedge clock) step = 1'b0;
      repeat (20) @(negedge clock);
      total++;
      if (q0.size() - b != k + 1 || int'(q0[q0.size()-1]) != exp_q[k]) begin
        bad++;
        $display("FAIL step_issue[%0d]: runs=%0d last=%0d, required runs=%0d last=%0d",
                 k, q0.size() - b, q0[q0.size()-1], k + 1, exp_q[k]);
      end
    end
    total++;
    if (fin0 !== 1'b1 || cnt0 !== 8'd3) begin
      bad++;
      $display("FAIL step_finish: fin=%b cnt=%0d, required fin=1 cnt=3", fin0, cnt0);
    end
    single_step = 1'b0;
  endtask

  task automatic test_timeout();
    int waits;
    proc_en = 1'b0;
    stop_addr = 5'd5;
    pulse_start();
    total++;
    if (run0 !== 1'b1 || din0 !== 5'd0) begin
      bad++;
      $display("FAIL tmo_issue: run=%b din=%0d, required run=1 din=0", run0, din0);
    end
    waits = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (terr0) break;
      waits++;
    end
    total++;
    if (waits != 32 || terr0 !== 1'b1) begin
      bad++;
      $display("FAIL tmo_latency: wait cycles=%0d terr=%b, required 32 and 1", waits, terr0);
    end
    total++;
    if (din0 !== 5'd0 || busy0 !== 1'b0 || fin0 !== 1'b0) begin
      bad++;
      $display("FAIL tmo_state: din=%0d busy=%b fin=%b, required 0 0 0", din0, busy0, fin0);
    end
    proc_en = 1'b1;
    proc_lat = 4;
    pulse_start();
    total++;
    if (run0 !== 1'b1 || terr0 !== 1'b0 || din0 !== 5'd0) begin
      bad++;
      $display("FAIL tmo_restart: run=%b terr=%b din=%0d, required 1 0 0", run0, terr0, din0);
    end
    for (int i = 0; i < 200 && !fin0; i++) @(negedge clock);
    total++;
    if (fin0 !== 1'b1 || cnt0 !== 8'd6) begin
      bad++;
      $display("FAIL tmo_rerun: fin=%b cnt=%0d, required fin=1 cnt=6", fin0, cnt0);
    end
  endtask

  task automatic test_wrap_stuck_done();
    int b;
    int n;
    @(negedge clock) reset = 1'b0;
    @(negedge clock) reset = 1'b1;
    b = q1.size();
    proc_lat = 2;
    proc_hold = 3;
    stop_addr = 5'd1;
    model_prog(30, 1);
    pulse_start();
    for (int i = 0; i < 300 && !fin1; i++) @(negedge clock);
    n = q1.size() - b;
    total++;
    if (fin1 !== 1'b1 || n != exp_q.size() || cnt1 !== 8'd4 || din1 !== 5'd1) begin
      bad++;
      $display("FAIL wrap_final: fin=%b runs=%0d cnt=%0d din=%0d, required 1 %0d 4 1",
               fin1, n, cnt1, din1, exp_q.size());
    end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      total++;
      if (int'(q1[b+i]) != exp_q[i] || dq1[b+i] !== 1'b0) begin
        bad++;
        $display("FAIL wrap_addr[%0d]: got %0d done=%b, required %0d done=0",
                 i, q1[b+i], dq1[b+i], exp_q[i]);
      end
      if (i > 0) begin
        total++;
        if (t1[b+i] - t1[b+i-1] != proc_lat + proc_hold + 1) begin
          bad++;
          $display("FAIL wrap_gap[%0d]: got %0d, required %0d", i,
                   t1[b+i] - t1[b+i-1], proc_lat + proc_hold + 1);
        end
      end
    end
  endtask

  task automatic test_abort();
    int b;
    @(negedge clock) reset = 1'b0;
    @(negedge clock) reset = 1'b1;
    b = q0.size();
    proc_lat = 20;
    proc_hold = 1;
    stop_addr = 5'd5;
    pulse_start();
    for (int i = 0; i < 300 && (q0.size() - b) < 3; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    total++;
    if (din0 !== 5'd2 || busy0 !== 1'b1 || cnt0 !== 8'd2) begin
      bad++;
      $display("FAIL abort_pre: din=%0d busy=%b cnt=%0d, required 2 1 2", din0, busy0, cnt0);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (run0 !== 1'b0 || busy0 !== 1'b0 || cnt0 !== 8'd0 || din0 !== 5'd0) begin
      bad++;
      $display("FAIL abort_now: run=%b busy=%b cnt=%0d din=%0d, required all 0",
               run0, busy0, cnt0, din0);
    end
    @(negedge clock) reset = 1'b1;
    proc_lat = 4;
    pulse_start();
    total++;
    if (run0 !== 1'b1 || din0 !== 5'd0) begin
      bad++;
      $display("FAIL abort_restart: run=%b din=%0d, required run=1 din=0", run0, din0);
    end
    for (int i = 0; i < 200 && !fin0; i++) @(negedge clock);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_free_run();
    test_random_runs();
    test_single_step();
    test_timeout();
    test_wrap_stuck_done();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
